bcd_up_down_counter: RTL and testbench



---
 rtl/bcd_pkg.sv | 9 +
 rtl/bcd_digit.sv | 43 ++++
 rtl/bcd_up_down_counter.sv | 37 +++
 tb/tb_bcd_up_down_counter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit type and limits
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD up/down digit with carry/borrow chaining
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       up_down,
    input  logic       cin,
    output bcd_digit_t q,
    output logic       cout
);

    bcd_digit_t digit_q;
    bcd_digit_t digit_d;
    logic       illegal;
    logic       at_limit;

    // Next digit value and carry/borrow out; an illegal code is always
    // corrected on the next edge, even when this digit is not stepping.
    always_comb begin
        illegal  = (digit_q > BCD_MAX);
        at_limit = up_down ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN);
        cout     = cin & (at_limit | illegal);
        digit_d  = digit_q;
        if (illegal || (cin && at_limit)) begin
            digit_d = up_down ? BCD_MIN : BCD_MAX;
        end else if (cin) begin
            digit_d = up_down ? (digit_q + 4'd1) : (digit_q - 4'd1);
        end
    end

    // Digit register, cleared asynchronously while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign q = digit_q;

endmodule

// File: rtl/bcd_up_down_counter.sv
// rtl/bcd_up_down_counter.sv - cascaded multi-digit BCD up/down counter
module bcd_up_down_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  up_down,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc
);

    // carry[k] enables digit k; digit 0 always steps.
    logic [DIGITS:0] carry;

    assign carry[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_t digit_val;

        bcd_digit u_digit (
            .clk     (clk),
            .reset   (reset),
            .up_down (up_down),
            .cin     (carry[k]),
            .q       (digit_val),
            .cout    (carry[k+1])
        );

        assign count[4*k +: 4] = digit_val;
    end

    // Terminal count is the ripple carry out of the most significant digit.
    assign tc = carry[DIGITS];

endmodule

// File: tb/tb_bcd_up_down_counter.sv
// tb/tb_bcd_up_down_counter.sv - scoreboard testbench for bcd_up_down_counter
module tb_bcd_up_down_counter;

    typedef struct {
        logic [31:0] cnt;
        logic        tc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       up_down1 = 1'b1;
    logic       up_down2 = 1'b1;
    logic [3:0] count1;
    logic       tc1;
    logic [7:0] count2;
    logic       tc2;

    int   n_checks = 0;
    int   n_fail = 0;
    int   m1 = 0;
    int   m2 = 0;
    exp_t sb1[$];
    exp_t sb2[$];
    exp_t e;

    bcd_up_down_counter #(.DIGITS(1)) dut1 (
        .clk(clk), .reset(reset), .up_down(up_down1), .count(count1), .tc(tc1)
    );

    bcd_up_down_counter #(.DIGITS(2)) dut2 (
        .clk(clk), .reset(reset), .up_down(up_down2), .count(count2), .tc(tc2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] to_bcd(input int v, input int d);
        logic [31:0] r = '0;
        int t = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int next_val(input int v, input logic dir, input int modulus);
        return dir ? (v + 1) % modulus : (v + modulus - 1) % modulus;
    endfunction

    task automatic drive1(input logic dir);
        up_down1 = dir;
        m1 = next_val(m1, dir, 10);
        sb1.push_back('{to_bcd(m1, 1), dir ? (m1 == 9) : (m1 == 0)});
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input logic dir);
        up_down2 = dir;
        m2 = next_val(m2, dir, 100);
        sb2.push_back('{to_bcd(m2, 2), dir ? (m2 == 99) : (m2 == 0)});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #7;
        n_checks++;
        if (count1 !== 4'h0) begin
            $display("FAIL reset_count1: got %h want 0", count1); n_fail++;
        end
        n_checks++;
        if (tc1 !== 1'b0) begin
            $display("FAIL reset_tc_up: got %b want 0", tc1); n_fail++;
        end
        n_checks++;
        if (count2 !== 8'h00) begin
            $display("FAIL reset_count2: got %h want 00", count2); n_fail++;
        end
        up_down1 = 1'b0;
        #1;
        n_checks++;
        if (tc1 !== 1'b1) begin
            $display("FAIL reset_tc_down: got %b want 1", tc1); n_fail++;
        end
        up_down1 = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        m1 = 0;
        m2 = 0;
    endtask

    task automatic test_up_count;
        for (int i = 0; i < 11; i++) begin
            drive1(1'b1);
            e = sb1.pop_front();
            n_checks++;
            if (count1 !== e.cnt[3:0] || tc1 !== e.tc) begin
                $display("FAIL up_count step %0d: got %h/%b want %h/%b", i, count1, tc1, e.cnt[3:0], e.tc);
                n_fail++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_down_wrap;
        for (int i = 0; i < 2; i++) begin
            drive1(1'b1);
            e = sb1.pop_front();
            @(negedge clk);
        end
        n_checks++;
        if (count1 !== 4'h3) begin
            $display("FAIL down_start: got %h want 3", count1); n_fail++;
        end
        for (int i = 0; i < 5; i++) begin
            drive1(1'b0);
            e = sb1.pop_front();
            n_checks++;
            if (count1 !== e.cnt[3:0] || tc1 !== e.tc) begin
                $display("FAIL down_wrap step %0d: got %h/%b want %h/%b", i, count1, tc1, e.cnt[3:0], e.tc);
                n_fail++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset;
        for (int pass = 0; pass < 2; pass++) begin
            while (m1 != 6) begin
                drive1(1'b1);
                e = sb1.pop_front();
                @(negedge clk);
            end
            n_checks++;
            if (count1 !== 4'h6) begin
                $display("FAIL async_pre pass %0d: got %h want 6", pass, count1); n_fail++;
            end
            #2;
            reset = 1'b0;
            #1;
            n_checks++;
            if (count1 !== 4'h0) begin
                $display("FAIL async_clear pass %0d: got %h want 0", pass, count1); n_fail++;
            end
            m1 = 0;
            m2 = 0;
            @(negedge clk);
            reset = 1'b1;
            drive1(pass == 0);
            e = sb1.pop_front();
            n_checks++;
            if (count1 !== e.cnt[3:0] || tc1 !== e.tc) begin
                $display("FAIL async_resume pass %0d: got %h/%b want %h/%b", pass, count1, tc1, e.cnt[3:0], e.tc);
                n_fail++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_toggle;
        logic [3:0] want [3];
        want[0] = 4'h6; want[1] = 4'h5; want[2] = 4'h6;
        while (m1 != 5) begin
            drive1(1'b0);
            e = sb1.pop_front();
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            drive1((i % 2) == 0);
            e = sb1.pop_front();
            n_checks++;
            if (count1 !== want[i] || count1 !== e.cnt[3:0] || tc1 !== e.tc) begin
                $display("FAIL toggle step %0d: got %h/%b want %h/%b", i, count1, tc1, want[i], e.tc);
                n_fail++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_two_digit;
        reset = 1'b0;
        #1;
        n_checks++;
        if (count2 !== 8'h00) begin
            $display("FAIL two_reset: got %h want 00", count2); n_fail++;
        end
        reset = 1'b1;
        m1 = 0;
        m2 = 0;
        for (int i = 0; i < 100; i++) begin
            drive2(1'b1);
            e = sb2.pop_front();
            n_checks++;
            if (count2 !== e.cnt[7:0] || tc2 !== e.tc) begin
                $display("FAIL two_up step %0d: got %h/%b want %h/%b", i, count2, tc2, e.cnt[7:0], e.tc);
                n_fail++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (count2 !== 8'h00) begin
            $display("FAIL two_up_wrap: got %h want 00", count2); n_fail++;
        end
        for (int i = 0; i < 90; i++) begin
            drive2(1'b0);
            e = sb2.pop_front();
            n_checks++;
            if (count2 !== e.cnt[7:0] || tc2 !== e.tc) begin
                $display("FAIL two_down step %0d: got %h/%b want %h/%b", i, count2, tc2, e.cnt[7:0], e.tc);
                n_fail++;
            end
            if (i == 0) begin
                n_checks++;
                if (count2 !== 8'h99) begin
                    $display("FAIL two_down_wrap: got %h want 99", count2); n_fail++;
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (count2 !== 8'h10) begin
            $display("FAIL two_at_10: got %h want 10", count2); n_fail++;
        end
        drive2(1'b0);
        e = sb2.pop_front();
        n_checks++;
        if (count2 !== 8'h09 || e.cnt[7:0] !== count2) begin
            $display("FAIL two_10_to_09: got %h want 09", count2); n_fail++;
        end
        @(negedge clk);
    endtask

    task automatic test_illegal;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        m1 = 0;
        for (int pass = 0; pass < 2; pass++) begin
            up_down1 = (pass == 0);
            force dut1.g_digit[0].u_digit.digit_q = 4'hC;
            #1;
            release dut1.g_digit[0].u_digit.digit_q;
            #1;
            n_checks++;
            if (tc1 !== 1'b1) begin
                $display("FAIL illegal_carry pass %0d: got %b want 1", pass, tc1); n_fail++;
            end
            m1 = (pass == 0) ? 9 : 0;
            drive1(pass == 0);
            e = sb1.pop_front();
            n_checks++;
            if (count1 !== e.cnt[3:0]) begin
                $display("FAIL illegal_load pass %0d: got %h want %h", pass, count1, e.cnt[3:0]);
                n_fail++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_wrap();
        test_async_reset();
        test_toggle();
        test_two_digit();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
